i2c_target_ctrl: RTL and testbench

Control FSM for the I2C target datapath (start/stop detectors, SIPO shifter, bit counter, address checker, register pointer, register file, SDA output generator, master-ACK sampler). It sequences one complete bus transaction:
- address phase
- register-pointer phase
- write data bytes, or read data bytes
All datapath enables and clears come from this block. It sits between the synchronizer/edge-detect front end and the datapath, and runs entirely in the system clock domain.

---
 rtl/i2c_target_ctrl.sv | 157 +++++++++++++++
 tb/tb_i2c_target_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl: sequences one I2C target transaction (address, pointer, write or
// read data) and drives every datapath enable and clear. All outputs are registered.
module i2c_target_ctrl #(
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       SCL_posedge,
    input  logic       SCL_negedge,
    input  logic       bit_done,
    input  logic       addr_valid,
    input  logic [7:0] rx_byte,
    input  logic       master_ack,
    output logic       clear_start,
    output logic       clear_stop,
    output logic       shift_en,
    output logic       count_clear,
    output logic       count_en,
    output logic       sel_load,
    output logic       sel_inc,
    output logic       mem_we,
    output logic       send_ack,
    output logic       out_en,
    output logic       busy,
    output logic       timeout
);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, TX, TX_ACK, WAIT_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             clear_start_q, clear_start_d;
    logic             clear_stop_q, clear_stop_d;
    logic             shift_en_q, shift_en_d;
    logic             count_clear_q, count_clear_d;
    logic             count_en_q, count_en_d;
    logic             sel_load_q, sel_load_d;
    logic             sel_inc_q, sel_inc_d;
    logic             mem_we_q, mem_we_d;
    logic             send_ack_q, send_ack_d;
    logic             out_en_q, out_en_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             start_pend, stop_pend, tmo_hit, inc_pulse;

    // A sticky flag still reads set in the cycle its clear pulse is out; that is the
    // event already handled, not a new one.
    assign start_pend = start & ~clear_start_q;
    assign stop_pend  = stop & ~clear_stop_q;
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (state_q != IDLE)
                        && (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d       = state_q;
        clear_start_d = 1'b0;
        clear_stop_d  = 1'b0;
        timeout_d     = 1'b0;
        inc_pulse     = 1'b0;
        tmo_cnt_d     = ((SCL_posedge || SCL_negedge) || (state_q == IDLE)) ? '0 :
                        ((&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1));

        if (stop_pend) begin
            state_d       = IDLE;
            clear_stop_d  = 1'b1;
            clear_start_d = start_pend;
        end else if (start_pend) begin
            state_d       = ADDR;
            clear_start_d = 1'b1;
        end else if (tmo_hit) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
        end else if (SCL_negedge) begin
            case (state_q)
                ADDR:      if (bit_done) state_d = addr_valid ? ADDR_ACK : WAIT_STOP;
                PTR:       if (bit_done) state_d = (32'(rx_byte) >= NUM_REGS) ? WAIT_STOP : PTR_ACK;
                WDATA:     if (bit_done) state_d = WDATA_ACK;
                TX:        if (bit_done) state_d = TX_ACK;
                ADDR_ACK:  state_d = rx_byte[0] ? TX : PTR;
                PTR_ACK,
                WDATA_ACK: state_d = WDATA;
                TX_ACK: begin
                    if (master_ack) begin
                        state_d   = TX;
                        inc_pulse = 1'b1;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end

        // Level outputs follow the state being entered so they line up with it.
        shift_en_d    = state_d inside {ADDR, PTR, WDATA};
        count_en_d    = state_d inside {ADDR, PTR, WDATA, TX};
        count_clear_d = count_en_d && ((state_d != state_q) || clear_start_d);
        sel_load_d    = (state_d == PTR_ACK);
        mem_we_d      = (state_d == WDATA_ACK);
        sel_inc_d     = mem_we_d | inc_pulse;
        send_ack_d    = state_d inside {ADDR_ACK, PTR_ACK, WDATA_ACK};
        out_en_d      = (state_d == TX);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            clear_start_q <= 1'b0;
            clear_stop_q  <= 1'b0;
            shift_en_q    <= 1'b0;
            count_clear_q <= 1'b0;
            count_en_q    <= 1'b0;
            sel_load_q    <= 1'b0;
            sel_inc_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            send_ack_q    <= 1'b0;
            out_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            clear_start_q <= clear_start_d;
            clear_stop_q  <= clear_stop_d;
            shift_en_q    <= shift_en_d;
            count_clear_q <= count_clear_d;
            count_en_q    <= count_en_d;
            sel_load_q    <= sel_load_d;
            sel_inc_q     <= sel_inc_d;
            mem_we_q      <= mem_we_d;
            send_ack_q    <= send_ack_d;
            out_en_q      <= out_en_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
        end
    end

    assign clear_start = clear_start_q;
    assign clear_stop  = clear_stop_q;
    assign shift_en    = shift_en_q;
    assign count_clear = count_clear_q;
    assign count_en    = count_en_q;
    assign sel_load    = sel_load_q;
    assign sel_inc     = sel_inc_q;
    assign mem_we      = mem_we_q;
    assign send_ack    = send_ack_q;
    assign out_en      = out_en_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_i2c_target_ctrl.sv
// tb_i2c_target_ctrl: vector table, directed transactions and a randomized run
// against a transaction-level model of the I2C target control FSM.
module tb_i2c_target_ctrl;
    localparam int unsigned NREGS = 32;
    localparam int unsigned TMO   = 100;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, SCL_posedge = 1'b0, SCL_negedge = 1'b0;
    logic       bit_done = 1'b0, addr_valid = 1'b0, master_ack = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       clear_start, clear_stop, shift_en, count_clear, count_en, sel_load;
    logic       sel_inc, mem_we, send_ack, out_en, busy, timeout;
    logic [11:0] outs;

    int checks = 0;
    int errors = 0;

    // {clear_start, clear_stop, shift_en, count_clear, count_en, sel_load,
    //  sel_inc, mem_we, send_ack, out_en, busy, timeout}
    assign outs = {clear_start, clear_stop, shift_en, count_clear, count_en, sel_load,
                   sel_inc, mem_we, send_ack, out_en, busy, timeout};

    i2c_target_ctrl #(.NUM_REGS(NREGS), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .SCL_posedge(SCL_posedge), .SCL_negedge(SCL_negedge), .bit_done(bit_done),
        .addr_valid(addr_valid), .rx_byte(rx_byte), .master_ack(master_ack),
        .clear_start(clear_start), .clear_stop(clear_stop), .shift_en(shift_en),
        .count_clear(count_clear), .count_en(count_en), .sel_load(sel_load),
        .sel_inc(sel_inc), .mem_we(mem_we), .send_ack(send_ack), .out_en(out_en),
        .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Minimal pointer/register-file datapath driven by the controller's enables.
    logic [4:0] ptr;
    logic [7:0] regs [32];
    always @(posedge clock) begin
        if (reset) begin
            ptr <= 5'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
        end else begin
            if (SCL_negedge && sel_load) ptr <= rx_byte[4:0];
            if (SCL_negedge && mem_we) regs[ptr] <= rx_byte;
            if (sel_inc && (SCL_negedge || !mem_we)) ptr <= ptr + 5'd1;
        end
    end

    typedef struct {
        logic st, sp, ne, bd, av;
        logic [7:0] rx;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic sp, input logic ne, input logic bd,
                                input logic av, input logic [7:0] rx, input logic [11:0] exp);
        vec_t v;
        v.st = st; v.sp = sp; v.ne = ne; v.bd = bd; v.av = av; v.rx = rx; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; return at the next falling edge.
    task automatic drive(input logic st, input logic sp, input logic ne, input logic pe,
                         input logic bd, input logic av, input logic [7:0] rx, input logic ma);
        start = st; stop = sp; SCL_negedge = ne; SCL_posedge = pe;
        bit_done = bd; addr_valid = av; rx_byte = rx; master_ack = ma;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        drive(L, L, L, L, L, L, 8'h00, L);
    endtask

    vec_t        tbl [13];
    logic        r_st, r_sp, r_ne, r_pe, r_bd, r_av, r_ma, st_e, sp_e, scl_edge, hit, cc, inc;
    logic [7:0]  r_rx;
    logic [11:0] e;
    logic        m_act, m_wait, m_ack;
    int          m_kind, m_cnt, nxt_cnt, frz;

    initial begin
        // Write transaction: START, 0x40, pointer 0x03, data 0xA5, 0x5A, STOP.
        tbl[0]  = mk(H, L, L, L, L, 8'h00, 12'hB82);
        tbl[1]  = mk(L, L, L, L, L, 8'h00, 12'h282);
        tbl[2]  = mk(L, L, H, L, L, 8'h00, 12'h282);
        tbl[3]  = mk(L, L, H, H, H, 8'h40, 12'h00A);
        tbl[4]  = mk(L, L, H, L, L, 8'h40, 12'h382);
        tbl[5]  = mk(L, L, H, H, L, 8'h03, 12'h04A);
        tbl[6]  = mk(L, L, H, L, L, 8'h03, 12'h382);
        tbl[7]  = mk(L, L, H, H, L, 8'hA5, 12'h03A);
        tbl[8]  = mk(L, L, H, L, L, 8'hA5, 12'h382);
        tbl[9]  = mk(L, L, H, H, L, 8'h5A, 12'h03A);
        tbl[10] = mk(L, L, H, L, L, 8'h5A, 12'h382);
        tbl[11] = mk(L, H, L, L, L, 8'h00, 12'h400);
        tbl[12] = mk(L, L, L, L, L, 8'h00, 12'h000);

        repeat (2) @(negedge clock);
        check("reset_outs", 32'(outs), 32'h0);
        reset = 1'b0;
        idle();
        check("idle_after_reset", 32'(outs), 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].ne, L, tbl[i].bd, tbl[i].av, tbl[i].rx, L);
            check($sformatf("wr_row%0d", i), 32'(outs), 32'(tbl[i].exp));
        end
        check("wr_reg3", 32'(regs[3]), 32'hA5);
        check("wr_reg4", 32'(regs[4]), 32'h5A);
        check("wr_ptr_end", 32'(ptr), 32'd5);

        // Address mismatch: parked until STOP.
        drive(H, L, L, L, L, L, 8'h00, L);
        drive(L, L, H, L, H, L, 8'h42, L);
        check("mis_no_ack", 32'(outs), 32'h002);
        for (int i = 0; i < 3; i++) begin
            drive(L, L, H, L, H, H, 8'h40, L);
            check($sformatf("mis_wait%0d", i), 32'(outs), 32'h002);
        end
        drive(L, H, L, L, L, L, 8'h00, L);
        check("mis_stop", 32'(outs), 32'h400);

        // Read: set pointer 0x1F, repeated START, 0x41, ACK then NACK.
        drive(H, L, L, L, L, L, 8'h00, L);
        drive(L, L, H, L, H, H, 8'h40, L);
        drive(L, L, H, L, L, L, 8'h40, L);
        drive(L, L, H, L, H, L, 8'h1F, L);
        drive(L, L, H, L, L, L, 8'h1F, L);
        check("rd_ptr_load", 32'(ptr), 32'h1F);
        drive(H, L, L, L, L, L, 8'h00, L);
        check("rd_rstart", 32'(outs), 32'hB82);
        drive(L, L, H, L, H, H, 8'h41, L);
        check("rd_addr_ack", 32'(outs), 32'h00A);
        drive(L, L, H, L, L, L, 8'h41, L);
        check("rd_tx1", 32'(outs), 32'h186);
        drive(L, L, H, L, H, L, 8'h00, L);
        check("rd_tx_ack1", 32'(outs), 32'h002);
        drive(L, L, H, L, L, L, 8'h00, H);
        check("rd_mack", 32'(outs), 32'h1A6);
        idle();
        check("rd_tx2", 32'(outs), 32'h086);
        check("rd_ptr_wrap", 32'(ptr), 32'h00);
        drive(L, L, H, L, H, L, 8'h00, L);
        check("rd_tx_ack2", 32'(outs), 32'h002);
        drive(L, L, H, L, L, L, 8'h00, L);
        check("rd_nack_wait", 32'(outs), 32'h002);
        drive(L, L, H, L, H, L, 8'h00, H);
        check("rd_still_wait", 32'(outs), 32'h002);
        drive(L, H, L, L, L, L, 8'h00, L);
        check("rd_stop", 32'(outs), 32'h400);

        // Pointer 0x20 is out of range: NACK, no register changes.
        drive(H, L, L, L, L, L, 8'h00, L);
        drive(L, L, H, L, H, H, 8'h40, L);
        drive(L, L, H, L, L, L, 8'h40, L);
        drive(L, L, H, L, H, L, 8'h20, L);
        check("oob_no_ack", 32'(outs), 32'h002);
        drive(L, L, H, L, L, L, 8'h20, L);
        check("oob_wait", 32'(outs), 32'h002);
        drive(L, H, L, L, L, L, 8'h00, L);
        check("oob_ptr", 32'(ptr), 32'h00);
        check("oob_reg3", 32'(regs[3]), 32'hA5);

        // Simultaneous START and STOP: STOP wins, both flags cleared.
        drive(H, L, L, L, L, L, 8'h00, L);
        drive(L, L, H, L, H, H, 8'h40, L);
        check("ss_addr_ack", 32'(outs), 32'h00A);
        drive(H, H, L, L, L, L, 8'h00, L);
        check("ss_both", 32'(outs), 32'hC00);
        idle();
        check("ss_idle", 32'(outs), 32'h000);

        // SCL frozen in PTR: TIMEOUT_CYCLES edge-free cycles, then a one-cycle pulse.
        drive(H, L, L, L, L, L, 8'h00, L);
        drive(L, L, H, L, H, H, 8'h40, L);
        drive(L, L, H, L, L, L, 8'h40, L);
        for (int n = 1; n <= int'(TMO) + 2; n++) begin
            idle();
            check($sformatf("tmo_n%0d", n), 32'(outs),
                  (n <= int'(TMO)) ? 32'h282 : ((n == int'(TMO) + 1) ? 32'h001 : 32'h000));
        end

        // Reset in WDATA_ACK clears everything at once.
        drive(H, L, L, L, L, L, 8'h00, L);
        drive(L, L, H, L, H, H, 8'h40, L);
        drive(L, L, H, L, L, L, 8'h40, L);
        drive(L, L, H, L, H, L, 8'h03, L);
        drive(L, L, H, L, L, L, 8'h03, L);
        drive(L, L, H, L, H, L, 8'hA5, L);
        check("rst_in_wdack", 32'(outs), 32'h03A);
        #2 reset = 1'b1;
        #1 check("rst_async", 32'(outs), 32'h000);
        @(negedge clock);
        check("rst_held", 32'(outs), 32'h000);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check($sformatf("rst_idle%0d", i), 32'(outs), 32'h000);
        end

        // Randomized run against a transaction-level model.
        m_act = 0; m_wait = 0; m_ack = 0; m_kind = 0; m_cnt = 0; frz = 0; e = '0;
        for (int i = 0; i < 4000; i++) begin
            if (frz > 0) frz--;
            else if ($urandom_range(0, 299) == 0) frz = $urandom_range(95, 110);
            r_st = ($urandom_range(0, 39) == 0);
            r_sp = ($urandom_range(0, 59) == 0);
            r_ne = (frz == 0) && ($urandom_range(0, 2) == 0);
            r_pe = (frz == 0) && !r_ne && ($urandom_range(0, 2) == 0);
            r_bd = ($urandom_range(0, 2) == 0);
            r_av = ($urandom_range(0, 3) != 0);
            r_ma = ($urandom_range(0, 3) != 0);
            r_rx = 8'($urandom_range(0, 47));

            // Phase model: kind 0=address 1=pointer 2=write data 3=read data.
            st_e = r_st && !e[11];
            sp_e = r_sp && !e[10];
            scl_edge = r_ne || r_pe;
            hit = m_act && (m_cnt >= int'(TMO));
            nxt_cnt = (scl_edge || !m_act) ? 0 : m_cnt + 1;
            cc = 0; inc = 0; e = '0;
            if (sp_e) begin
                m_act = 0; e[10] = 1; e[11] = st_e;
            end else if (st_e) begin
                m_act = 1; m_wait = 0; m_ack = 0; m_kind = 0; e[11] = 1; cc = 1;
            end else if (hit) begin
                m_act = 0; e[0] = 1;
            end else if (m_act && !m_wait && r_ne) begin
                if (!m_ack) begin
                    if (r_bd) begin
                        if ((m_kind == 0 && !r_av) || (m_kind == 1 && r_rx >= NREGS)) m_wait = 1;
                        else m_ack = 1;
                    end
                end else if (m_kind == 3 && !r_ma) begin
                    m_wait = 1;
                end else begin
                    inc = (m_kind == 3);
                    m_kind = (m_kind == 0) ? (r_rx[0] ? 3 : 1) : ((m_kind == 3) ? 3 : 2);
                    m_ack = 0; cc = 1;
                end
            end
            m_cnt = nxt_cnt;
            if (m_act && !m_wait) begin
                if (!m_ack) begin
                    e[9] = (m_kind != 3); e[7] = 1; e[2] = (m_kind == 3);
                end else if (m_kind != 3) begin
                    e[3] = 1; e[6] = (m_kind == 1); e[5] = (m_kind == 2); e[4] = (m_kind == 2);
                end
            end
            e[1] = m_act; e[8] = cc; e[5] = e[5] | inc;

            drive(r_st, r_sp, r_ne, r_pe, r_bd, r_av, r_rx, r_ma);
            check($sformatf("rand%0d", i), 32'(outs), 32'(e));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
